// File: rtl/seq_multiplier_if.sv
// Execute <-> multiplier handshake: request, operands and mode in; result, done pulse and stall out.
interface seq_multiplier_if #(
  parameter int WORD = 64
);
  logic            mult_start;
  logic [1:0]      mult_mode;
  logic [WORD-1:0] operand_a;
  logic [WORD-1:0] operand_b;
  logic [WORD-1:0] result;
  logic            multiplier_done;
  logic            stall;

  modport master (
    output mult_start, mult_mode, operand_a, operand_b,
    input  result, multiplier_done, stall
  );

  modport slave (
    input  mult_start, mult_mode, operand_a, operand_b,
    output result, multiplier_done, stall
  );
endinterface

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier for MUL/SMULH/UMULH: WORD iterations plus one sign-fix cycle.
// Start accepted only in IDLE; stall is held from the request cycle until the done pulse.
module seq_multiplier #(
  parameter int WORD = 64
) (
  input  logic               clk,
  input  logic               reset,
  seq_multiplier_if.slave    mif
);
  localparam int CW = $clog2(WORD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WORD-1:0]   mcand_q, mcand_d;
  logic [WORD-1:0]   mplier_q, mplier_d;
  logic [2*WORD-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;
  logic              high_q, high_d;
  logic [WORD-1:0]   result_q, result_d;
  logic              done_q, done_d;

  logic [WORD:0]     acc_sum;
  logic [2*WORD-1:0] prod;
  logic              is_signed;
  logic              a_neg;
  logic              b_neg;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    high_d    = high_q;
    result_d  = result_q;
    done_d    = 1'b0;
    is_signed = (mif.mult_mode == 2'b01);
    a_neg     = is_signed && mif.operand_a[WORD-1];
    b_neg     = is_signed && mif.operand_b[WORD-1];

    // Carry out of the upper half is kept so the right shift loses nothing.
    acc_sum = {1'b0, acc_q[2*WORD-1:WORD]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    prod    = neg_q ? -acc_q : acc_q;

    case (state_q)
      S_IDLE: begin
        if (mif.mult_start) begin
          state_d  = S_RUN;
          count_d  = '0;
          acc_d    = '0;
          mcand_d  = a_neg ? -mif.operand_a : mif.operand_a;
          mplier_d = b_neg ? -mif.operand_b : mif.operand_b;
          neg_d    = a_neg ^ b_neg;
          high_d   = (mif.mult_mode == 2'b01) || (mif.mult_mode == 2'b10);
        end
      end
      S_RUN: begin
        acc_d    = {acc_sum, acc_q[WORD-1:1]};
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == CW'(WORD - 1)) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        result_d = high_q ? prod[2*WORD-1:WORD] : prod[WORD-1:0];
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      high_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      high_q   <= high_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Stall covers the request cycle itself so Decode freezes before the start edge.
  assign mif.stall           = (state_q != S_IDLE) || mif.mult_start;
  assign mif.result          = result_q;
  assign mif.multiplier_done = done_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed corner cases plus randomized operations against an arithmetic model.
module tb_seq_multiplier;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;

  seq_multiplier_if #(.WORD(64)) mif ();

  seq_multiplier #(.WORD(64)) dut (
    .clk   (clk),
    .reset (reset),
    .mif   (mif)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mif.multiplier_done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b);
    logic [127:0]        up;
    logic signed [127:0] sp;
    up = {64'd0, a} * {64'd0, b};
    sp = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
    case (m)
      2'b01:   return sp[127:64];
      2'b10:   return up[127:64];
      default: return up[63:0];
    endcase
  endfunction

  // Entered at posedge+1 after the edge numbered k0 (start edge = 0); returns in the done cycle.
  task automatic wait_done(input int k0, output int k, output int drops);
    bit seen;
    seen  = 1'b0;
    k     = k0;
    drops = 0;
    while (!seen && k < 200) begin
      @(negedge clk);
      if (mif.multiplier_done === 1'b1) seen = 1'b1;
      else begin
        if (mif.stall !== 1'b1) drops++;
        @(posedge clk);
        #1;
        k++;
      end
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b, input string tag);
    int k, drops;
    logic [63:0] exp_v;
    exp_v          = ref_mul(m, a, b);
    mif.mult_mode  = m;
    mif.operand_a  = a;
    mif.operand_b  = b;
    mif.mult_start = 1'b1;
    #1;
    check({tag, "_stall_req"}, 64'(mif.stall), 64'd1);
    @(posedge clk);
    #1;
    mif.mult_start = 1'b0;
    mif.operand_a  = {$urandom, $urandom};
    mif.operand_b  = {$urandom, $urandom};
    mif.mult_mode  = 2'($urandom_range(0, 3));
    wait_done(0, k, drops);
    check({tag, "_latency"}, 64'(k), 64'd65);
    check({tag, "_stall_run"}, 64'(drops), 64'd0);
    check({tag, "_result"}, mif.result, exp_v);
    check({tag, "_stall_done"}, 64'(mif.stall), 64'd0);
  endtask

  task automatic gap();
    @(posedge clk);
    #1;
    check("done_pulse_width", 64'(mif.multiplier_done), 64'd0);
  endtask

  initial begin
    int k, drops, c0;
    logic [63:0] ra, rb;
    logic [1:0]  rm;

    reset          = 1'b1;
    mif.mult_start = 1'b0;
    mif.mult_mode  = 2'b00;
    mif.operand_a  = '0;
    mif.operand_b  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_result", mif.result, 64'd0);
    check("rst_done", 64'(mif.multiplier_done), 64'd0);
    check("rst_stall", 64'(mif.stall), 64'd0);
    @(posedge clk);
    #1;

    run_op(2'b00, 64'd3, 64'd5, "mul_3x5");                gap();
    run_op(2'b10, '1, '1, "umulh_ones");                    gap();
    run_op(2'b00, '1, '1, "mul_ones");                      gap();
    run_op(2'b11, 64'd12, 64'd11, "mode11");                gap();
    run_op(2'b01, '1, '1, "smulh_m1m1");                    gap();
    run_op(2'b01, '1, 64'd2, "smulh_m1x2");                 gap();
    run_op(2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, "smulh_min"); gap();
    run_op(2'b01, 64'd0, -64'sd7, "smulh_0xm7");            gap();

    // Start ignored mid-run; operand changes after the start edge are ignored.
    c0             = done_cnt;
    mif.mult_mode  = 2'b00;
    mif.operand_a  = 64'd6;
    mif.operand_b  = 64'd7;
    mif.mult_start = 1'b1;
    @(posedge clk);
    #1;
    mif.mult_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    mif.mult_start = 1'b1;
    mif.operand_a  = 64'd2;
    mif.operand_b  = 64'd2;
    @(posedge clk);
    #1;
    mif.mult_start = 1'b0;
    mif.operand_a  = 64'd99;
    wait_done(11, k, drops);
    check("ign_latency", 64'(k), 64'd65);
    check("ign_result", mif.result, 64'd42);
    repeat (20) @(posedge clk);
    #1;
    check("ign_single_done", 64'(done_cnt - c0), 64'd1);

    // Reset mid-operation aborts silently.
    c0             = done_cnt;
    mif.operand_a  = 64'd9;
    mif.operand_b  = 64'd9;
    mif.mult_start = 1'b1;
    @(posedge clk);
    #1;
    mif.mult_start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_result", mif.result, 64'd0);
    check("abort_stall", 64'(mif.stall), 64'd0);
    check("abort_done", 64'(mif.multiplier_done), 64'd0);
    repeat (80) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt - c0), 64'd0);
    check("abort_result_hold", mif.result, 64'd0);
    run_op(2'b00, 64'd4, 64'd4, "after_abort");              gap();

    // Back-to-back: second start issued in the done cycle of the first.
    run_op(2'b00, 64'd5, 64'd5, "b2b_first");
    run_op(2'b00, 64'd2, 64'd3, "b2b_second");              gap();

    for (int i = 0; i < 20; i++) begin
      rm = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       ra = 64'h8000_0000_0000_0000;
        1:       ra = '1;
        default: ra = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 3))
        0:       rb = 64'd0;
        1:       rb = {32'd0, $urandom};
        default: rb = {$urandom, $urandom};
      endcase
      run_op(rm, ra, rb, "rand");
      gap();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
